// File: rtl/dwsep_conv_pkg.sv
// Shared widths and the requantisation helper for the depthwise-separable conv layer.
package dwsep_conv_pkg;

    localparam int ACC_W   = 32;
    localparam int SHIFT_W = 5;

    // Arithmetic right shift, then clamp into the n-bit signed range.
    function automatic logic signed [ACC_W-1:0] shift_sat(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      sh,
        input int                      n
    );
        logic signed [ACC_W-1:0] v, hi, lo;
        v  = acc >>> sh;
        hi = (ACC_W'(1) <<< (n - 1)) - ACC_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dwsep_conv_dw_stage.sv
// Per-channel KxK depthwise conv: line buffers feed an ExE window, then MAC and requantise.
module dwsep_conv_dw_stage
    import dwsep_conv_pkg::*;
#(
    parameter int N        = 16,
    parameter int IC       = 3,
    parameter int W        = 8,
    parameter int K        = 3,
    parameter int STRIDE   = 1,
    parameter int DILATION = 1,
    parameter int RW       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [IC*N-1:0]       i_pix,
    input  logic [RW-1:0]         i_row,
    input  logic [RW-1:0]         i_col,
    input  logic [IC*K*K*N-1:0]   i_weight,
    input  logic [IC*ACC_W-1:0]   i_bias,
    input  logic [IC*SHIFT_W-1:0] i_shift,
    output logic                  o_vld,
    output logic [IC*N-1:0]       o_dout
);

    localparam int E = DILATION*(K-1) + 1;

    logic [IC*N-1:0] w_rows [E];
    logic [IC*N-1:0] r_win  [E][E];
    logic [2:0]      r_vld_pipe;
    logic            w_take;

    // w_rows[j] is the pixel j padded rows above the incoming one, same column.
    assign w_rows[0] = i_pix;
    for (genvar j = 0; j < E-1; j++) begin : g_lb
        dwsep_conv_line_buffer #(.WIDTH(IC*N), .DEPTH(W)) u_lb (
            .clk    (clk),
            .i_en   (i_vld),
            .i_din  (w_rows[j]),
            .o_dout (w_rows[j+1])
        );
    end

    // r_win[j][k] holds padded pixel (r-j, c-k) after the shift for (r,c).
    always_ff @(posedge clk) begin
        if (i_vld) begin
            for (int j = 0; j < E; j++) begin
                r_win[j][0] <= w_rows[j];
                for (int k = 1; k < E; k++) r_win[j][k] <= r_win[j][k-1];
            end
        end
    end

    assign w_take = i_vld && (int'(i_row) >= E-1) && (int'(i_col) >= E-1)
                 && ((int'(i_row) - (E-1)) % STRIDE == 0)
                 && ((int'(i_col) - (E-1)) % STRIDE == 0);

    always_ff @(posedge clk) begin
        if (rst) r_vld_pipe <= '0;
        else     r_vld_pipe <= {r_vld_pipe[1:0], w_take};
    end
    assign o_vld = r_vld_pipe[2];

    for (genvar c = 0; c < IC; c++) begin : g_ch
        logic signed [ACC_W-1:0] w_sum, r_acc, w_sat;
        logic [N-1:0]            r_q;

        always_comb begin
            w_sum = '0;
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    w_sum = w_sum
                          + ACC_W'($signed(r_win[E-1-ky*DILATION][E-1-kx*DILATION][c*N +: N]))
                          * ACC_W'($signed(i_weight[(c*K*K + ky*K + kx)*N +: N]));
        end

        assign w_sat = shift_sat(r_acc + $signed(i_bias[c*ACC_W +: ACC_W]),
                                 i_shift[c*SHIFT_W +: SHIFT_W], N);

        always_ff @(posedge clk) begin
            if (r_vld_pipe[0]) r_acc <= w_sum;
            if (r_vld_pipe[1]) r_q   <= N'(w_sat);
        end

        assign o_dout[c*N +: N] = r_q;
    end

endmodule

// File: rtl/dwsep_conv_line_buffer.sv
// One padded-row delay line: o_dout is the pixel pushed DEPTH enables ago.
module dwsep_conv_line_buffer #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/dwsep_conv_pad_stage.sv
// Walks the padded raster; border positions self-advance with zeros, interior waits for input.
module dwsep_conv_pad_stage #(
    parameter int N  = 16,
    parameter int IC = 3,
    parameter int S  = 6,
    parameter int P  = 1,
    parameter int RW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            input_vld,
    output logic            input_rdy,
    input  logic [IC*N-1:0] input_din,
    output logic            o_vld,
    output logic [IC*N-1:0] o_pix,
    output logic [RW-1:0]   o_row,
    output logic [RW-1:0]   o_col
);

    localparam int W = S + 2*P;
    localparam logic [RW-1:0] LO   = RW'(P);
    localparam logic [RW-1:0] HI   = RW'(P + S - 1);
    localparam logic [RW-1:0] LAST = RW'(W - 1);

    logic [RW-1:0]   r_row, r_col, r_prow, r_pcol;
    logic            r_vld;
    logic [IC*N-1:0] r_pix;
    logic            w_int, w_adv;

    assign w_int     = (r_row >= LO) && (r_row <= HI) && (r_col >= LO) && (r_col <= HI);
    assign w_adv     = !w_int || input_vld;
    assign input_rdy = w_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_prow <= '0;
            r_pcol <= '0;
            r_vld  <= 1'b0;
            r_pix  <= '0;
        end else begin
            r_vld <= w_adv;
            if (w_adv) begin
                r_pix  <= w_int ? input_din : '0;
                r_prow <= r_row;
                r_pcol <= r_col;
                if (r_col == LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign o_vld = r_vld;
    assign o_pix = r_pix;
    assign o_row = r_prow;
    assign o_col = r_pcol;

endmodule

// File: rtl/dwsep_conv_pw_stage.sv
// 1x1 pointwise conv across channels: MAC stage, then bias/shift/saturate into the output register.
module dwsep_conv_pw_stage
    import dwsep_conv_pkg::*;
#(
    parameter int N  = 16,
    parameter int IC = 3,
    parameter int OC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [IC*N-1:0]       i_din,
    input  logic [IC*OC*N-1:0]    i_weight,
    input  logic [OC*ACC_W-1:0]   i_bias,
    input  logic [OC*SHIFT_W-1:0] i_shift,
    output logic                  o_vld,
    output logic [OC*N-1:0]       o_dout
);

    logic [1:0] r_vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) r_vld_pipe <= '0;
        else     r_vld_pipe <= {r_vld_pipe[0], i_vld};
    end
    assign o_vld = r_vld_pipe[1];

    for (genvar o = 0; o < OC; o++) begin : g_oc
        logic signed [ACC_W-1:0] w_sum, r_acc, w_sat;
        logic [N-1:0]            r_q;

        always_comb begin
            w_sum = '0;
            for (int i = 0; i < IC; i++)
                w_sum = w_sum + ACC_W'($signed(i_din[i*N +: N]))
                              * ACC_W'($signed(i_weight[(o*IC + i)*N +: N]));
        end

        assign w_sat = shift_sat(r_acc + $signed(i_bias[o*ACC_W +: ACC_W]),
                                 i_shift[o*SHIFT_W +: SHIFT_W], N);

        always_ff @(posedge clk) begin
            if (i_vld) r_acc <= w_sum;
        end

        // Output register holds between valid pixels.
        always_ff @(posedge clk) begin
            if (rst)                r_q <= '0;
            else if (r_vld_pipe[0]) r_q <= N'(w_sat);
        end

        assign o_dout[o*N +: N] = r_q;
    end

endmodule

// File: rtl/dwsep_conv.sv
// Streaming depthwise-separable conv layer: zero pad -> KxK depthwise -> 1x1 pointwise.
module dwsep_conv
    import dwsep_conv_pkg::*;
#(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int INPUT_SIZE     = 6,
    parameter int OUTPUT_CHANNEL = 3,
    parameter int OUTPUT_SIZE    = 6,
    parameter int KERNEL_SIZE    = 3,
    parameter int STRIDE         = 1,
    parameter int PADDING        = 1,
    parameter int DILATION       = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 input_vld,
    output logic                                                 input_rdy,
    input  logic [INPUT_CHANNEL*N-1:0]                           input_din,
    input  logic [INPUT_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*N-1:0]   dconv_weight_din,
    input  logic [INPUT_CHANNEL*OUTPUT_CHANNEL*N-1:0]            pconv_weight_din,
    input  logic [INPUT_CHANNEL*ACC_W-1:0]                       dconv_bias_din,
    input  logic [OUTPUT_CHANNEL*ACC_W-1:0]                      pconv_bias_din,
    input  logic [INPUT_CHANNEL*SHIFT_W-1:0]                     dconv_shift_din,
    input  logic [OUTPUT_CHANNEL*SHIFT_W-1:0]                    pconv_shift_din,
    output logic [OUTPUT_CHANNEL*N-1:0]                          conv_dout,
    output logic                                                 conv_dout_vld,
    output logic                                                 conv_dout_end
);

    localparam int W       = INPUT_SIZE + 2*PADDING;
    localparam int RW      = (W > 1) ? $clog2(W) : 1;
    localparam int OUT_PIX = OUTPUT_SIZE*OUTPUT_SIZE;
    localparam int CW      = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_PIX - 1);

    logic                       w_pad_vld, w_dw_vld;
    logic [INPUT_CHANNEL*N-1:0] w_pad_pix, w_dw_dout;
    logic [RW-1:0]              w_pad_row, w_pad_col;
    logic [CW-1:0]              r_out_cnt;

    dwsep_conv_pad_stage #(
        .N(N), .IC(INPUT_CHANNEL), .S(INPUT_SIZE), .P(PADDING), .RW(RW)
    ) u_pad (
        .clk       (clk),
        .rst       (rst),
        .input_vld (input_vld),
        .input_rdy (input_rdy),
        .input_din (input_din),
        .o_vld     (w_pad_vld),
        .o_pix     (w_pad_pix),
        .o_row     (w_pad_row),
        .o_col     (w_pad_col)
    );

    dwsep_conv_dw_stage #(
        .N(N), .IC(INPUT_CHANNEL), .W(W), .K(KERNEL_SIZE),
        .STRIDE(STRIDE), .DILATION(DILATION), .RW(RW)
    ) u_dw (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (w_pad_vld),
        .i_pix    (w_pad_pix),
        .i_row    (w_pad_row),
        .i_col    (w_pad_col),
        .i_weight (dconv_weight_din),
        .i_bias   (dconv_bias_din),
        .i_shift  (dconv_shift_din),
        .o_vld    (w_dw_vld),
        .o_dout   (w_dw_dout)
    );

    dwsep_conv_pw_stage #(
        .N(N), .IC(INPUT_CHANNEL), .OC(OUTPUT_CHANNEL)
    ) u_pw (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (w_dw_vld),
        .i_din    (w_dw_dout),
        .i_weight (pconv_weight_din),
        .i_bias   (pconv_bias_din),
        .i_shift  (pconv_shift_din),
        .o_vld    (conv_dout_vld),
        .o_dout   (conv_dout)
    );

    always_ff @(posedge clk) begin
        if (rst)                r_out_cnt <= '0;
        else if (conv_dout_vld) r_out_cnt <= (r_out_cnt == CNT_LAST) ? '0 : r_out_cnt + 1'b1;
    end

    assign conv_dout_end = conv_dout_vld && (r_out_cnt == CNT_LAST);

endmodule

// File: tb/tb_dwsep_conv.sv
// Randomised frame-level bench for dwsep_conv with an arithmetic reference model and scoreboard.
module tb_dwsep_conv;

    localparam int N = 16, IC = 3, S = 6, OC = 3, OS = 6, K = 3, STR = 1, P = 1, D = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   input_vld = 1'b0;
    logic                   input_rdy;
    logic [IC*N-1:0]        input_din = '0;
    logic [IC*K*K*N-1:0]    dconv_weight_din = '0;
    logic [IC*OC*N-1:0]     pconv_weight_din = '0;
    logic [IC*32-1:0]       dconv_bias_din = '0;
    logic [OC*32-1:0]       pconv_bias_din = '0;
    logic [IC*5-1:0]        dconv_shift_din = '0;
    logic [OC*5-1:0]        pconv_shift_din = '0;
    logic [OC*N-1:0]        conv_dout;
    logic                   conv_dout_vld;
    logic                   conv_dout_end;

    dwsep_conv #(
        .N(N), .INPUT_CHANNEL(IC), .INPUT_SIZE(S), .OUTPUT_CHANNEL(OC), .OUTPUT_SIZE(OS),
        .KERNEL_SIZE(K), .STRIDE(STR), .PADDING(P), .DILATION(D)
    ) dut (
        .clk(clk), .rst(rst), .input_vld(input_vld), .input_rdy(input_rdy), .input_din(input_din),
        .dconv_weight_din(dconv_weight_din), .pconv_weight_din(pconv_weight_din),
        .dconv_bias_din(dconv_bias_din), .pconv_bias_din(pconv_bias_din),
        .dconv_shift_din(dconv_shift_din), .pconv_shift_din(pconv_shift_din),
        .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld), .conv_dout_end(conv_dout_end)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int frame_in [IC][S][S];
    int dw_w [IC][K][K];
    int pw_w [OC][IC];
    int db [IC], ds [IC], pb [OC], ps [OC];
    int exp_out [OS][OS][OC];
    logic [OC*N:0] exp_q [$];
    int  n_out = 0, n_end = 0;
    bit  got_first = 0;
    time t_first, t_acc7;
    logic [OC*N-1:0] last_dout = '0;

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_ports();
        for (int c = 0; c < IC; c++) begin
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    dconv_weight_din[(c*K*K + ky*K + kx)*N +: N] = N'(dw_w[c][ky][kx]);
            dconv_bias_din[c*32 +: 32] = db[c];
            dconv_shift_din[c*5 +: 5]  = 5'(ds[c]);
        end
        for (int o = 0; o < OC; o++) begin
            for (int i = 0; i < IC; i++) pconv_weight_din[(o*IC + i)*N +: N] = N'(pw_w[o][i]);
            pconv_bias_din[o*32 +: 32] = pb[o];
            pconv_shift_din[o*5 +: 5]  = 5'(ps[o]);
        end
    endtask

    // dw_mode: 0 centre tap only, 1 all taps one, 2 random; pw always identity unless randomised later
    task automatic cfg(input int dw_mode);
        for (int c = 0; c < IC; c++) begin
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    dw_w[c][ky][kx] = (dw_mode == 1) ? 1 : (dw_mode == 2) ? rnd(-8, 8)
                                    : ((ky == K/2 && kx == K/2) ? 1 : 0);
            db[c] = 0; ds[c] = 0;
        end
        for (int o = 0; o < OC; o++) begin
            for (int i = 0; i < IC; i++) pw_w[o][i] = (o == i) ? 1 : 0;
            pb[o] = 0; ps[o] = 0;
        end
    endtask

    // mode 0: c*100+r*6+x, 1: constant v, 2: random full range
    task automatic fill(input int mode, input int v);
        for (int c = 0; c < IC; c++)
            for (int r = 0; r < S; r++)
                for (int x = 0; x < S; x++)
                    frame_in[c][r][x] = (mode == 0) ? c*100 + r*S + x : (mode == 1) ? v : rnd(-32768, 32767);
    endtask

    // Reference: direct convolution over the zero-padded frame, then channel mix.
    task automatic push_frame();
        int dv [IC][OS][OS];
        logic [OC*N:0] e;
        for (int c = 0; c < IC; c++)
            for (int oy = 0; oy < OS; oy++)
                for (int ox = 0; ox < OS; ox++) begin
                    int acc = 0;
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            int r = oy*STR + ky*D - P;
                            int x = ox*STR + kx*D - P;
                            if (r >= 0 && r < S && x >= 0 && x < S)
                                acc += frame_in[c][r][x] * dw_w[c][ky][kx];
                        end
                    dv[c][oy][ox] = sat((acc + db[c]) >>> ds[c]);
                end
        for (int oy = 0; oy < OS; oy++)
            for (int ox = 0; ox < OS; ox++) begin
                e = '0;
                e[OC*N] = (oy == OS-1 && ox == OS-1);
                for (int o = 0; o < OC; o++) begin
                    int acc = 0;
                    for (int i = 0; i < IC; i++) acc += dv[i][oy][ox] * pw_w[o][i];
                    exp_out[oy][ox][o] = sat((acc + pb[o]) >>> ps[o]);
                    e[o*N +: N] = N'(exp_out[oy][ox][o]);
                end
                exp_q.push_back(e);
            end
    endtask

    // Entered and left at posedge+1. Returns cycles where valid was offered but not taken.
    task automatic drive(input int npix, input bit hold, output int n_low);
        int idx = 0, budget = 0;
        bit acc;
        time te;
        n_low = 0;
        while (idx < npix) begin
            input_vld = hold || ($urandom_range(0, 3) != 0);
            for (int c = 0; c < IC; c++)
                input_din[c*N +: N] = input_vld ? N'(frame_in[c][idx/S][idx%S]) : N'($urandom);
            acc = input_vld && input_rdy;
            if (input_vld && !input_rdy) n_low++;
            @(posedge clk);
            te = $time;
            #1;
            if (acc) begin
                if (idx == 7) t_acc7 = te;
                idx++;
            end
            if (++budget > 2000) begin
                checks++; errors++;
                $display("FAIL drive_timeout: accepted %0d of %0d pixels", idx, npix);
                break;
            end
        end
        input_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        input_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        got_first = 0;
        chk("reset_vld", int'(conv_dout_vld), 0);
        chk("reset_end", int'(conv_dout_end), 0);
        chk("reset_dout", int'(conv_dout != '0), 0);
        chk("reset_rdy", int'(input_rdy), 0);
        rst = 1'b0;
    endtask

    // Scoreboard: every valid output is matched in order; outputs hold while idle.
    always @(negedge clk) begin
        if (rst) begin
            last_dout = '0;
        end else if (conv_dout_vld) begin
            n_out++;
            if (conv_dout_end) n_end++;
            if (!got_first) begin got_first = 1; t_first = $time; end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got dout=%h end=%b, expected none", conv_dout, conv_dout_end);
            end else begin
                logic [OC*N:0] e;
                e = exp_q.pop_front();
                if ({conv_dout_end, conv_dout} !== e)
                    begin
                        errors++;
                        $display("FAIL output: got dout=%h end=%b, expected dout=%h end=%b",
                                 conv_dout, conv_dout_end, e[OC*N-1:0], e[OC*N]);
                    end
            end
            last_dout = conv_dout;
        end else begin
            checks++;
            if (conv_dout_end || conv_dout !== last_dout) begin
                errors++;
                $display("FAIL idle_hold: got dout=%h end=%b, expected dout=%h end=0",
                         conv_dout, conv_dout_end, last_dout);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, o0, e0;
        @(posedge clk); #1;
        do_reset();

        // identity path, continuous valid
        cfg(0); set_ports(); fill(0, 0); push_frame();
        chk("model_identity", exp_out[2][3][1], 115);
        o0 = n_out;
        drive(S*S, 1'b1, nl);
        chk("border_stalls", nl, 19);
        drain("identity");
        chk("identity_count", n_out - o0, OS*OS);
        chk("latency", int'(t_first - t_acc7), 55);

        // zero-padding border counts
        cfg(1); set_ports(); fill(1, 1); push_frame();
        chk("model_corner", exp_out[0][0][0], 4);
        chk("model_edge", exp_out[0][3][1], 6);
        chk("model_interior", exp_out[2][2][2], 9);
        drive(S*S, 1'b0, nl); drain("border");

        // bias and shift
        cfg(0); for (int c = 0; c < IC; c++) begin db[c] = 8; ds[c] = 2; end
        set_ports(); fill(1, 0); push_frame();
        chk("model_dw_bias", exp_out[1][4][0], 2);
        drive(S*S, 1'b0, nl); drain("dw_bias");
        for (int o = 0; o < OC; o++) pb[o] = -5;
        set_ports(); push_frame();
        chk("model_pw_bias", exp_out[5][0][2], -3);
        drive(S*S, 1'b0, nl); drain("pw_bias");

        // saturation both directions
        cfg(1); set_ports(); fill(1, 32767); push_frame();
        chk("model_sat_hi", exp_out[3][3][0], 32767);
        drive(S*S, 1'b0, nl); drain("sat_hi");
        fill(1, -32768); push_frame();
        chk("model_sat_lo", exp_out[3][3][2], -32768);
        drive(S*S, 1'b0, nl); drain("sat_lo");

        // pointwise mixing
        cfg(0);
        pw_w[0] = '{1, 1, 1}; pw_w[1] = '{1, -1, 0}; pw_w[2] = '{0, 0, 2};
        set_ports(); fill(0, 0); push_frame();
        chk("model_mix0", exp_out[2][3][0], 345);
        chk("model_mix1", exp_out[2][3][1], -100);
        chk("model_mix2", exp_out[2][3][2], 430);
        drive(S*S, 1'b0, nl); drain("mix");

        // random configurations and frames
        for (int t = 0; t < 3; t++) begin
            cfg(2);
            for (int c = 0; c < IC; c++) begin db[c] = rnd(-100000, 100000); ds[c] = rnd(0, 6); end
            for (int o = 0; o < OC; o++) begin
                for (int i = 0; i < IC; i++) pw_w[o][i] = rnd(-20, 20);
                pb[o] = rnd(-50000, 50000); ps[o] = rnd(0, 4);
            end
            set_ports(); fill(2, 0); push_frame();
            drive(S*S, 1'b0, nl); drain("random");
        end

        // mid-frame reset, then two back-to-back frames
        fill(2, 0); push_frame();
        drive(10, 1'b0, nl);
        do_reset();
        o0 = n_out; e0 = n_end;
        fill(2, 0); push_frame(); drive(S*S, 1'b0, nl);
        fill(2, 0); push_frame(); drive(S*S, 1'b0, nl);
        drain("restart");
        chk("restart_outputs", n_out - o0, 2*OS*OS);
        chk("restart_ends", n_end - e0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
